// File: rtl/serial_adder_n_pkg.sv
// Shared constants for the bit-serial adder: FSM state encodings.
// Latency: n/a (constants only).
// Backpressure: n/a.
package serial_adder_n_pkg;

  // Encodings are fixed so the bench and any debug tooling can decode the state register.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_n_fa_cell.sv
// One-bit full-adder cell, the only arithmetic element of the serial adder.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b, ci - operand bits and carry-in; s - sum bit; co - carry-out.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_n.sv
// Bit-serial adder: Sum = A + B + Cin, one bit per cycle, LSB first, through one fa_cell.
// Latency: start accepted at edge T -> done high in the cycle after edge T+WIDTH; one op per WIDTH+2 cycles.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped.
// Ports: clk, rst (sync, active-high); start, A, B, Cin - request and operands;
//        busy - not IDLE; done - one-cycle result strobe; Sum, Carry, Overflow - registered result.
module serial_adder_n
  import serial_adder_n_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             Overflow
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   s_q;
  logic               c_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               ovf_q;

  logic               sum_bit_d;
  logic               carry_d;
  logic [WIDTH-1:0]   s_d;

  fa_cell u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (c_q),
    .s  (sum_bit_d),
    .co (carry_d)
  );

  // Partial sum fills from the top; after WIDTH shifts bit 0 sits at index 0.
  assign s_d = {sum_bit_d, s_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            c_q     <= Cin;
            s_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ADD;
          end
        end
        ADD: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          s_q   <= s_d;
          c_q   <= carry_d;
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == LAST_BIT) begin
            // c_q still holds the carry into the MSB on this cycle.
            sum_q   <= s_d;
            carry_q <= carry_d;
            ovf_q   <= carry_d ^ c_q;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign Sum      = sum_q;
  assign Carry    = carry_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n at WIDTH=8: directed vector table,
// busy-start/reset corner sequences, and a randomised run against a behavioural model.
module tb_serial_adder_n;
  import serial_adder_n_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Carry;
  logic         Overflow;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
  } vec_t;

  vec_t vecs [11];

  serial_adder_n #(.WIDTH(W)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .busy     (busy),
    .done     (done),
    .Sum      (Sum),
    .Carry    (Carry),
    .Overflow (Overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue a start, then wait for done. lat counts edges from the start edge
  // (inclusive) through the edge that raises done; the spec'd value is WIDTH+1.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        output int lat, output bit got);
    start = 1'b1;
    A     = a;
    B     = b;
    Cin   = ci;
    tick();
    // Scramble operands so any late sampling shows up as a wrong result.
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    Cin   = 1'($urandom);
    lat   = 1;
    got   = 1'b0;
    while (!got && lat <= 20) begin
      if (done) got = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: no done within %0d edges, expected one", lat);
    end
  endtask

  initial begin
    int           lat;
    bit           got;
    int           n_done;
    logic [W-1:0] seen_sum;
    logic [W:0]   full;
    logic [W-1:0] ra, rb;
    logic         rc, rovf;

    vecs[0]  = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[6]  = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[7]  = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[9]  = '{8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 1'b0};
    vecs[10] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    Cin   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy",  64'(busy),     64'd0);
    check("reset_done",  64'(done),     64'd0);
    check("reset_sum",   64'(Sum),      64'd0);
    check("reset_carry", 64'(Carry),    64'd0);
    check("reset_ovf",   64'(Overflow), 64'd0);
    check("reset_state", 64'(u_dut.state_q), 64'(IDLE));

    // First vector starts on the first edge after reset release; each following
    // vector starts on the first IDLE cycle after the previous done.
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, lat, got);
      if (got) begin
        check($sformatf("vec%0d_latency", i), 64'(lat),      64'd9);
        check($sformatf("vec%0d_sum", i),     64'(Sum),      64'(vecs[i].sum));
        check($sformatf("vec%0d_carry", i),   64'(Carry),    64'(vecs[i].carry));
        check($sformatf("vec%0d_ovf", i),     64'(Overflow), 64'(vecs[i].ovf));
      end
      tick();
      check($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
      check($sformatf("vec%0d_busy_clr", i),   64'(busy), 64'd0);
    end

    // Result holds while idle.
    repeat (3) tick();
    check("hold_idle_sum", 64'(Sum), 64'h47);

    // start while busy is ignored; result holds during the new ADD.
    start = 1'b1; A = 8'h01; B = 8'h01; Cin = 1'b0;
    tick();
    start = 1'b0;
    n_done   = 0;
    seen_sum = '1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 2) begin start = 1'b1; A = 8'hAA; B = 8'h55; Cin = 1'b1; end
      if (i == 3) start = 1'b0;
      if (i == 4) begin
        check("hold_in_add_sum", 64'(Sum),  64'h47);
        check("busy_in_add",     64'(busy), 64'd1);
      end
      tick();
      if (done) begin
        n_done++;
        seen_sum = Sum;
      end
    end
    check("busy_start_done_count", 64'(n_done),   64'd1);
    check("busy_start_sum",        64'(seen_sum), 64'h02);
    check("busy_start_idle",       64'(busy),     64'd0);

    // Reset in the middle of ADD aborts the operation.
    run_op(8'h80, 8'h81, 1'b0, lat, got);
    if (got) check("pre_abort_result", 64'({Carry, Overflow, Sum}), 64'({1'b1, 1'b1, 8'h01}));
    tick();
    start = 1'b1; A = 8'h3C; B = 8'h0F; Cin = 1'b0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy",  64'(busy),     64'd0);
    check("abort_done",  64'(done),     64'd0);
    check("abort_sum",   64'(Sum),      64'd0);
    check("abort_carry", 64'(Carry),    64'd0);
    check("abort_ovf",   64'(Overflow), 64'd0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);
    run_op(8'h3C, 8'h0F, 1'b0, lat, got);
    if (got) begin
      check("post_abort_latency", 64'(lat), 64'd9);
      check("post_abort_result", 64'({Carry, Overflow, Sum}), 64'({1'b0, 1'b0, 8'h4B}));
    end
    tick();

    // Randomised back-to-back run against a behavioural model.
    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rc   = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      rovf = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
      run_op(ra, rb, rc, lat, got);
      if (got)
        check($sformatf("rand%0d a=%h b=%h c=%b", i, ra, rb, rc),
              64'({lat[7:0], Carry, Overflow, Sum}),
              64'({8'd9, full[W], rovf, full[W-1:0]}));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
